// File: rtl/rst_en_sequencer.sv
// rst_en_sequencer: ordered domain reset/enable generator keeping dom_en |-> dom_rst
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-low reset
//   start      power-up request, honoured only in IDLE
//   stop       orderly shutdown (abort in HOLD/SETTLE, drain from RUN)
//   fault      emergency shutdown, both outputs low at once
//   dom_rst    downstream reset, active-low (1 = domain out of reset)
//   dom_en     downstream enable
//   state      IDLE=0 HOLD=1 SETTLE=2 RUN=3 DRAIN=4
//   ready      one-cycle pulse on entry to RUN
//   fault_cnt  saturating count of faults taken outside IDLE
module rst_en_sequencer #(
    parameter int HOLD_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_CYCLES  = 3,
    parameter int FCW           = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           fault,
    output logic           dom_rst,
    output logic           dom_en,
    output logic [2:0]     state,
    output logic           ready,
    output logic [FCW-1:0] fault_cnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;
    localparam int MX = HOLD_CYCLES > SETTLE_CYCLES ?
                        (HOLD_CYCLES > DRAIN_CYCLES ? HOLD_CYCLES : DRAIN_CYCLES) :
                        (SETTLE_CYCLES > DRAIN_CYCLES ? SETTLE_CYCLES : DRAIN_CYCLES);
    localparam int CW = $clog2(MX + 1);
    state_t        st, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic          done, dom_rst_d, dom_en_d, ready_d;
    assign state = st;
    assign done  = cnt == '0;
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = (start && !fault) ? HOLD : IDLE;
            HOLD:    nxt = (fault || stop) ? IDLE : done ? SETTLE : HOLD;
            SETTLE:  nxt = (fault || stop) ? IDLE : done ? RUN : SETTLE;
            RUN:     nxt = fault ? IDLE : stop ? DRAIN : RUN;
            DRAIN:   nxt = (fault || done) ? IDLE : DRAIN;
            default: nxt = IDLE;
        endcase
        // counter is reloaded on every state entry, so a state lasts load+1 cycles
        cnt_n = (nxt != st) ?
                (nxt == HOLD   ? CW'(HOLD_CYCLES - 1)   :
                 nxt == SETTLE ? CW'(SETTLE_CYCLES - 1) :
                 nxt == DRAIN  ? CW'(DRAIN_CYCLES - 1)  : '0) :
                (done ? '0 : cnt - CW'(1));
        // outputs are decoded from the next state so they change on the entry edge
        dom_rst_d = nxt == SETTLE || nxt == RUN || nxt == DRAIN;
        dom_en_d  = nxt == RUN;
        ready_d   = nxt == RUN && st != RUN;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            st        <= IDLE;
            cnt       <= '0;
            dom_rst   <= 1'b0;
            dom_en    <= 1'b0;
            ready     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            st      <= nxt;
            cnt     <= cnt_n;
            dom_rst <= dom_rst_d;
            dom_en  <= dom_en_d;
            ready   <= ready_d;
            if (fault && st != IDLE && fault_cnt != '1)
                fault_cnt <= fault_cnt + FCW'(1);
        end
    end
endmodule

// File: tb/tb_rst_en_sequencer.sv
// tb_rst_en_sequencer: timestamp-based reference model, literal pins and random stress
module tb_rst_en_sequencer;
    localparam int H = 4, S = 2, D = 3, FCW = 4, FMAX = 15;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, fault = 1'b0;
    logic dom_rst, dom_en, ready;
    logic [2:0] state;
    logic [FCW-1:0] fault_cnt;
    int cyc = 0, checks = 0, passed = 0;
    int mode = 0, t0 = 0, t1 = 0, fc = 0, es = 0, er = 0;
    always #5 clk = ~clk;
    rst_en_sequencer #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S), .DRAIN_CYCLES(D), .FCW(FCW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .fault(fault),
        .dom_rst(dom_rst), .dom_en(dom_en), .state(state), .ready(ready), .fault_cnt(fault_cnt)
    );
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at edge %0d: got %0d, required %0d", name, cyc, act, exp);
    endtask
    task automatic wt(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // mode 0 = idle, 1 = powering up since edge t0, 2 = draining since edge t1
    always @(posedge clk) begin
        int cur;
        cur = es;
        cyc++;
        if (!rst) begin
            mode = 0;
            fc = 0;
        end else if (fault && cur != 0) begin
            mode = 0;
            fc = fc < FMAX ? fc + 1 : FMAX;
        end else if (stop && (cur == 1 || cur == 2)) mode = 0;
        else if (stop && cur == 3) begin
            mode = 2;
            t1 = cyc;
        end else if (start && !fault && cur == 0) begin
            mode = 1;
            t0 = cyc;
        end
        if (mode == 2 && cyc - t1 >= D) mode = 0;
        es = mode == 0 ? 0 :
             mode == 2 ? 4 :
             (cyc - t0 < H ? 1 : cyc - t0 < H + S ? 2 : 3);
        er = (es == 3 && cur != 3) ? 1 : 0;
    end
    always begin
        @(posedge clk);
        #1;
        chk("state", int'(state), es);
        chk("dom_rst", int'(dom_rst), (es >= 2) ? 1 : 0);
        chk("dom_en", int'(dom_en), (es == 3) ? 1 : 0);
        chk("ready", int'(ready), er);
        chk("fault_cnt", int'(fault_cnt), fc);
    end
    always @(edge clk) if (cyc > 0) chk("en_implies_rst", int'(dom_en && !dom_rst), 0);
    initial begin
        int b;
        wt(2);
        chk("rst_state", int'(state), 0);
        chk("rst_dom_rst", int'(dom_rst), 0);
        chk("rst_fault_cnt", int'(fault_cnt), 0);
        rst = 1'b1;
        wt(9); start = 1'b1;
        wt(10); start = 1'b0;
        chk("t1_hold", int'(state), 1);
        wt(14); chk("t1_dom_rst_up", int'(dom_rst), 1);
        wt(16); chk("t1_dom_en_up", int'(dom_en), 1); chk("t1_ready", int'(ready), 1);
        wt(17); chk("t1_ready_low", int'(ready), 0);
        wt(29); stop = 1'b1;
        wt(30); stop = 1'b0;
        chk("t2_en_low", int'(dom_en), 0); chk("t2_rst_high", int'(dom_rst), 1);
        wt(32); chk("t2_rst_held", int'(dom_rst), 1);
        wt(33); chk("t2_rst_low", int'(dom_rst), 0); chk("t2_idle", int'(state), 0);
        b = cyc + 2;
        wt(b - 1); start = 1'b1;
        wt(b); start = 1'b0;
        wt(b + 4); fault = 1'b1;
        wt(b + 5);
        chk("t3_idle", int'(state), 0); chk("t3_rst", int'(dom_rst), 0);
        chk("t3_en", int'(dom_en), 0); chk("t3_cnt", int'(fault_cnt), 1);
        wt(b + 9); fault = 1'b0;
        chk("t3_cnt_held", int'(fault_cnt), 1);
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            wt(cyc + 1); start = 1'b0; fault = 1'b1;
            wt(cyc + 1); fault = 1'b0;
        end
        chk("t4_saturate", int'(fault_cnt), 15);
        rst = 1'b0;
        wt(cyc + 1); rst = 1'b1;
        chk("t4_cnt_clear", int'(fault_cnt), 0);
        start = 1'b1;
        b = cyc + 1;
        wt(b); start = 1'b0;
        wt(b + 7); rst = 1'b0;
        wt(b + 8); rst = 1'b1;
        chk("t5_en", int'(dom_en), 0); chk("t5_rst", int'(dom_rst), 0); chk("t5_idle", int'(state), 0);
        start = 1'b1;
        b = cyc + 1;
        wt(b); start = 1'b0;
        wt(b + 1); start = 1'b1;
        wt(b + 2); start = 1'b0;
        wt(b + 4); chk("t5_restart_ignored", int'(state), 2);
        stop = 1'b1;
        wt(b + 5); stop = 1'b0;
        start = 1'b1;
        b = cyc + 1;
        wt(b); start = 1'b0;
        wt(b + 1); stop = 1'b1;
        wt(b + 2); stop = 1'b0;
        chk("t5_hold_abort", int'(state), 0);
        for (int i = 0; i < 10000; i++) begin
            start = $urandom_range(3) == 0;
            stop  = $urandom_range(15) == 0;
            fault = $urandom_range(31) == 0;
            rst   = $urandom_range(299) != 0;
            wt(cyc + 1);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
